// File: rtl/core_trace_checker.sv
// ---------------------------------------------------------------------------
// core_trace_checker
//
// Stimulus player and response checker for the accumulator core. A loadable
// vector memory holds {chk, ir, exp_acc, exp_pc} entries. A run drives one
// instruction per clock into the core. RESP_LAT cycles later it compares the
// core's {accum_value, pc} against the expected value. It reports pass/fail,
// a saturating error count and the details of the first failure.
//
// Ports
//   clk          rising-edge clock
//   CLB          asynchronous active-low reset
//   load_we      vector memory write enable (ignored while busy)
//   load_addr    vector memory write address
//   load_data    vector memory write data {chk, ir, exp_acc, exp_pc}
//   last_addr    index of the final vector of a run, sampled on start
//   start        single-cycle run request (ignored while busy)
//   input_ins    instruction driven to the core
//   core_clb     active-low reset driven to the core
//   accum_value  core accumulator
//   pc           core program counter
//   busy         run in progress
//   done         run finished, held until the next accepted start
//   pass         done and no mismatches
//   err_count    saturating mismatch count
//   fail_valid   first failure captured
//   fail_addr    vector index of the first mismatch
//   fail_obs     observed {accum_value, pc} at the first mismatch
// ---------------------------------------------------------------------------
module core_trace_checker #(
  parameter int OP_W         = 4,
  parameter int IMM_W        = 4,
  parameter int ACC_W        = 8,
  parameter int PC_W         = 8,
  parameter int ADDR_W       = 8,
  parameter int RESP_LAT     = 1,
  parameter int STOP_ON_FAIL = 0,
  parameter int ERR_CNT_W    = 8,
  localparam int IR_W        = OP_W + IMM_W,
  localparam int VEC_W       = 1 + IR_W + ACC_W + PC_W
) (
  input  logic                   clk,
  input  logic                   CLB,
  input  logic                   load_we,
  input  logic [ADDR_W-1:0]      load_addr,
  input  logic [VEC_W-1:0]       load_data,
  input  logic [ADDR_W-1:0]      last_addr,
  input  logic                   start,
  output logic [IR_W-1:0]        input_ins,
  output logic                   core_clb,
  input  logic [ACC_W-1:0]       accum_value,
  input  logic [PC_W-1:0]        pc,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [ERR_CNT_W-1:0]   err_count,
  output logic                   fail_valid,
  output logic [ADDR_W-1:0]      fail_addr,
  output logic [ACC_W+PC_W-1:0]  fail_obs
);

  localparam int          RES_W = ACC_W + PC_W;
  localparam int          DEPTH = 2 ** ADDR_W;
  localparam int unsigned LAT   = RESP_LAT;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] end_ptr;
  logic [1:0]        drain_cnt;

  // Vector memory: no reset, contents survive CLB.
  logic [VEC_W-1:0] mem [DEPTH];
  logic [VEC_W-1:0] rd_vec;
  logic             rd_chk;
  logic [IR_W-1:0]  rd_ir;
  logic [RES_W-1:0] rd_exp;

  // Response delay line; stage LAT-1 is the compare point.
  logic              dl_v    [LAT];
  logic              dl_chk  [LAT];
  logic [RES_W-1:0]  dl_exp  [LAT];
  logic [ADDR_W-1:0] dl_addr [LAT];

  logic             active;
  logic [RES_W-1:0] obs;
  logic             mismatch;
  logic             abort;

  always_ff @(posedge clk) begin
    if (load_we && !busy) begin
      mem[load_addr] <= load_data;
    end
  end

  assign rd_vec = mem[ptr];
  assign rd_chk = rd_vec[VEC_W-1];
  assign rd_ir  = rd_vec[RES_W +: IR_W];
  assign rd_exp = rd_vec[RES_W-1:0];

  assign active   = (state == S_RUN) || (state == S_DRAIN);
  assign obs      = {accum_value, pc};
  assign mismatch = active && dl_v[LAT-1] && dl_chk[LAT-1] &&
                    (obs != dl_exp[LAT-1]);
  assign abort    = (STOP_ON_FAIL != 0) && mismatch;

  assign busy      = active;
  assign core_clb  = active;
  assign input_ins = (state == S_RUN) ? rd_ir : '0;
  assign pass      = done && (err_count == '0);

  always_ff @(posedge clk or negedge CLB) begin
    if (!CLB) begin
      state      <= S_IDLE;
      ptr        <= '0;
      end_ptr    <= '0;
      drain_cnt  <= '0;
      done       <= 1'b0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      fail_addr  <= '0;
      fail_obs   <= '0;
      for (int unsigned i = 0; i < LAT; i++) begin
        dl_v[i]    <= 1'b0;
        dl_chk[i]  <= 1'b0;
        dl_exp[i]  <= '0;
        dl_addr[i] <= '0;
      end
    end else begin
      // Only RUN pushes valid entries; DRAIN shifts bubbles in behind them.
      dl_v[0]    <= (state == S_RUN);
      dl_chk[0]  <= rd_chk;
      dl_exp[0]  <= rd_exp;
      dl_addr[0] <= ptr;
      for (int unsigned i = 1; i < LAT; i++) begin
        dl_v[i]    <= dl_v[i-1];
        dl_chk[i]  <= dl_chk[i-1];
        dl_exp[i]  <= dl_exp[i-1];
        dl_addr[i] <= dl_addr[i-1];
      end

      if (mismatch) begin
        if (err_count != '1) begin
          err_count <= err_count + 1'b1;
        end
        if (!fail_valid) begin
          fail_valid <= 1'b1;
          fail_addr  <= dl_addr[LAT-1];
          fail_obs   <= obs;
        end
      end

      unique case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state      <= S_RUN;
            ptr        <= '0;
            end_ptr    <= last_addr;
            done       <= 1'b0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_addr  <= '0;
            fail_obs   <= '0;
          end
        end
        S_RUN: begin
          if (abort) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else if (ptr == end_ptr) begin
            state     <= S_DRAIN;
            drain_cnt <= '0;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        S_DRAIN: begin
          if (abort || (drain_cnt == 2'(RESP_LAT - 1))) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase

      // Stopping on a failure throws away whatever is still in flight.
      if (abort) begin
        for (int unsigned i = 0; i < LAT; i++) begin
          dl_v[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_core_trace_checker.sv
module tb_core_trace_checker;

  logic clk = 1'b0;
  logic clb = 1'b0;
  always #5 clk = ~clk;

  logic        load_we   = 1'b0;
  logic [7:0]  load_addr = '0;
  logic [24:0] load_data = '0;
  logic [7:0]  last_addr = '0;
  logic        start     = 1'b0;

  // Instances: 0 default, 1 STOP_ON_FAIL, 2 ERR_CNT_W=2, 3 RESP_LAT=3
  logic [7:0]  ins   [4];
  logic [3:0]  cclb, busy, done, pass_o, fval;
  logic [7:0]  e0, e1, e3;
  logic [1:0]  e2;
  logic [7:0]  faddr [4];
  logic [15:0] fobs  [4];

  // Core stand-ins: LOAD=1 (acc=imm), ADD=2, SUB=3, others NOP; pc+1 each cycle.
  logic [7:0]  cacc [4];
  logic [7:0]  cpc  [4];
  logic [15:0] dly1, dly2;

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (!cclb[i]) begin
        cacc[i] <= '0;
        cpc[i]  <= '0;
      end else begin
        case (ins[i][7:4])
          4'd1:    cacc[i] <= {4'b0, ins[i][3:0]};
          4'd2:    cacc[i] <= cacc[i] + {4'b0, ins[i][3:0]};
          4'd3:    cacc[i] <= cacc[i] - {4'b0, ins[i][3:0]};
          default: ;
        endcase
        cpc[i] <= cpc[i] + 8'd1;
      end
    end
    dly1 <= {cacc[3], cpc[3]};
    dly2 <= dly1;
  end

  core_trace_checker u0 (
    .clk(clk), .CLB(clb), .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
    .last_addr(last_addr), .start(start), .input_ins(ins[0]), .core_clb(cclb[0]),
    .accum_value(cacc[0]), .pc(cpc[0]), .busy(busy[0]), .done(done[0]), .pass(pass_o[0]),
    .err_count(e0), .fail_valid(fval[0]), .fail_addr(faddr[0]), .fail_obs(fobs[0]));

  core_trace_checker #(.STOP_ON_FAIL(1)) u1 (
    .clk(clk), .CLB(clb), .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
    .last_addr(last_addr), .start(start), .input_ins(ins[1]), .core_clb(cclb[1]),
    .accum_value(cacc[1]), .pc(cpc[1]), .busy(busy[1]), .done(done[1]), .pass(pass_o[1]),
    .err_count(e1), .fail_valid(fval[1]), .fail_addr(faddr[1]), .fail_obs(fobs[1]));

  core_trace_checker #(.ERR_CNT_W(2)) u2 (
    .clk(clk), .CLB(clb), .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
    .last_addr(last_addr), .start(start), .input_ins(ins[2]), .core_clb(cclb[2]),
    .accum_value(cacc[2]), .pc(cpc[2]), .busy(busy[2]), .done(done[2]), .pass(pass_o[2]),
    .err_count(e2), .fail_valid(fval[2]), .fail_addr(faddr[2]), .fail_obs(fobs[2]));

  core_trace_checker #(.RESP_LAT(3)) u3 (
    .clk(clk), .CLB(clb), .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
    .last_addr(last_addr), .start(start), .input_ins(ins[3]), .core_clb(cclb[3]),
    .accum_value(dly2[15:8]), .pc(dly2[7:0]), .busy(busy[3]), .done(done[3]), .pass(pass_o[3]),
    .err_count(e3), .fail_valid(fval[3]), .fail_addr(faddr[3]), .fail_obs(fobs[3]));

  // Free-running busy-cycle counters; runs take differences.
  int bcnt [4] = '{0, 0, 0, 0};
  int bbase [4];
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) if (busy[i]) bcnt[i] <= bcnt[i] + 1;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [7:0] err_of(input int i);
    case (i)
      0:       return e0;
      1:       return e1;
      2:       return {6'b0, e2};
      default: return e3;
    endcase
  endfunction

  logic [24:0] prog [256];
  logic [15:0] res  [256];

  function automatic logic [24:0] mkv(input logic c, input logic [3:0] op, input logic [3:0] imm,
                                      input logic [7:0] a, input logic [7:0] p);
    return {c, op, imm, a, p};
  endfunction

  // Architectural result {acc, pc} after each instruction of the program.
  task automatic golden(input int n);
    logic [7:0] acc;
    logic [3:0] op, imm;
    acc = '0;
    for (int k = 0; k < n; k++) begin
      op  = prog[k][23:20];
      imm = prog[k][19:16];
      if (op == 4'd1)      acc = {4'b0, imm};
      else if (op == 4'd2) acc = acc + {4'b0, imm};
      else if (op == 4'd3) acc = acc - {4'b0, imm};
      res[k] = {acc, 8'(k + 1)};
    end
  endtask

  task automatic load(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      load_we = 1'b1; load_addr = 8'(k); load_data = prog[k];
    end
    @(negedge clk);
    load_we = 1'b0;
  endtask

  task automatic run(input int last, input bit poke);
    @(negedge clk);
    last_addr = 8'(last);
    start = 1'b1;
    for (int i = 0; i < 4; i++) bbase[i] = bcnt[i];
    @(negedge clk);
    start = 1'b0;
    if (poke) begin
      load_we = 1'b1; load_addr = '0; load_data = '1;
      @(negedge clk);
      load_we = 1'b0;
    end
    for (int c = 0; c < 1000 && done != 4'hf; c++) @(negedge clk);
    check("run.done_all", {28'b0, done}, 32'hf);
  endtask

  task automatic expect_run(input int last);
    int nmis, f, lat, emax, eerr, ebusy;
    golden(last + 1);
    nmis = 0; f = 0;
    for (int k = last; k >= 0; k--) begin
      if (prog[k][24] && prog[k][15:0] != res[k]) begin
        nmis++;
        f = k;
      end
    end
    for (int i = 0; i < 4; i++) begin
      lat  = (i == 3) ? 3 : 1;
      emax = (i == 2) ? 3 : 255;
      if (i == 1) begin
        eerr  = (nmis > 0) ? 1 : 0;
        ebusy = (nmis > 0) ? f + lat + 1 : last + 1 + lat;
      end else begin
        eerr  = (nmis > emax) ? emax : nmis;
        ebusy = last + 1 + lat;
      end
      check($sformatf("u%0d.busy_cycles", i), bcnt[i] - bbase[i], ebusy);
      check($sformatf("u%0d.done", i), {31'b0, done[i]}, 1);
      check($sformatf("u%0d.pass", i), {31'b0, pass_o[i]}, (eerr == 0) ? 1 : 0);
      check($sformatf("u%0d.err_count", i), {24'b0, err_of(i)}, eerr);
      check($sformatf("u%0d.fail_valid", i), {31'b0, fval[i]}, (nmis > 0) ? 1 : 0);
      check($sformatf("u%0d.fail_addr", i), {24'b0, faddr[i]}, (nmis > 0) ? f : 0);
      check($sformatf("u%0d.fail_obs", i), {16'b0, fobs[i]}, (nmis > 0) ? {16'b0, res[f]} : 0);
      check($sformatf("u%0d.done_ins", i), {24'b0, ins[i]}, 0);
      check($sformatf("u%0d.done_core_clb", i), {31'b0, cclb[i]}, 0);
    end
  endtask

  task automatic check_reset(input string ph);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s.u%0d.ins", ph, i), {24'b0, ins[i]}, 0);
      check($sformatf("%s.u%0d.core_clb", ph, i), {31'b0, cclb[i]}, 0);
      check($sformatf("%s.u%0d.busy", ph, i), {31'b0, busy[i]}, 0);
      check($sformatf("%s.u%0d.done", ph, i), {31'b0, done[i]}, 0);
      check($sformatf("%s.u%0d.pass", ph, i), {31'b0, pass_o[i]}, 0);
      check($sformatf("%s.u%0d.err", ph, i), {24'b0, err_of(i)}, 0);
      check($sformatf("%s.u%0d.fail_valid", ph, i), {31'b0, fval[i]}, 0);
      check($sformatf("%s.u%0d.fail_addr", ph, i), {24'b0, faddr[i]}, 0);
      check($sformatf("%s.u%0d.fail_obs", ph, i), {16'b0, fobs[i]}, 0);
    end
  endtask

  task automatic set_s1();
    prog[0] = mkv(1'b1, 4'd1, 4'd5, 8'h05, 8'h01);
    prog[1] = mkv(1'b1, 4'd2, 4'd3, 8'h08, 8'h02);
    prog[2] = mkv(1'b1, 4'd2, 4'd1, 8'h09, 8'h03);
    prog[3] = mkv(1'b1, 4'd0, 4'd0, 8'h09, 8'h04);
  endtask

  int n;

  initial begin
    repeat (3) @(negedge clk);
    check_reset("por");
    clb = 1'b1;

    // Scenario 1: clean program.
    set_s1();
    load(4); run(3, 1'b0); expect_run(3);

    // Scenario 2: vector 2 expects the wrong accumulator.
    prog[2][15:0] = 16'h0A03;
    load(4); run(3, 1'b0); expect_run(3);

    // Scenario 3: same corruption, compare disabled.
    prog[2][24] = 1'b0;
    load(4); run(3, 1'b0); expect_run(3);

    // Scenario 4: six vectors, mismatch at vector 1.
    set_s1();
    prog[1][15:0] = 16'h0902;
    prog[4] = mkv(1'b1, 4'd2, 4'd2, 8'h0B, 8'h05);
    prog[5] = mkv(1'b1, 4'd0, 4'd0, 8'h0B, 8'h06);
    load(6); run(5, 1'b0); expect_run(5);

    // Scenario 5: five vectors, all mismatching.
    prog[1][15:0] = 16'h0802;
    for (int k = 0; k < 5; k++) prog[k][15] = ~prog[k][15];
    load(5); run(4, 1'b0); expect_run(4);

    // Scenario 6: CLB dropped in run cycle 2, then clean reruns without reload.
    set_s1();
    load(4);
    @(negedge clk);
    last_addr = 8'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    clb = 1'b0;
    #1;
    check_reset("abort");
    @(negedge clk);
    clb = 1'b1;
    run(3, 1'b1); expect_run(3);
    run(3, 1'b0); expect_run(3);

    // Randomized programs.
    for (int t = 0; t < 25; t++) begin
      n = $urandom_range(1, 24);
      for (int k = 0; k < n; k++)
        prog[k] = mkv(1'b1, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 8'h00, 8'h00);
      golden(n);
      for (int k = 0; k < n; k++) begin
        prog[k][15:0] = res[k];
        if ($urandom_range(0, 3) == 0) prog[k][15:0] = prog[k][15:0] ^ 16'(1 << $urandom_range(0, 15));
        prog[k][24] = ($urandom_range(0, 4) != 0);
      end
      load(n); run(n - 1, 1'b0); expect_run(n - 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
